// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial sensor frame reader.
// Holds the FSM state enum, config commands and the read-command helper.
package inert_pkg;

  typedef enum logic [2:0] {
    INIT_WAIT,
    CFG0,
    CFG1,
    CFG2,
    IDLE,
    RD_L,
    RD_H,
    PUBLISH
  } state_t;

  localparam logic [15:0] CMD_CFG0 = 16'h0D02;
  localparam logic [15:0] CMD_CFG1 = 16'h1160;
  localparam logic [15:0] CMD_CFG2 = 16'h1440;
  localparam logic        RD_BIT   = 1'b1;

  function automatic logic [15:0] rd_cmd(input logic [6:0] a);
    return {RD_BIT, a, 8'h00};
  endfunction

endpackage

// File: rtl/inert_multi_intf_sync2.sv
// Two-flop synchronizer for the asynchronous sensor INT line.
// Ports: clk, rst (sync, active high), d_i async in, q_o synced out.
module inert_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/inert_multi_intf.sv
// Inertial sensor reader: startup config, then on INT reads NUM_AXES
// 16-bit axes over an external SPI master and publishes whole frames.
// Ports: clk, rst, INT, spi_done, spi_rd_data in; spi_wrt, spi_cmd,
// axis_data, vld, wdog_to out. Macro INERT_WDOG_EN adds a watchdog.
module inert_multi_intf
  import inert_pkg::*;
#(
  parameter int          NUM_AXES  = 3,
  parameter logic [6:0]  BASE_ADDR = 7'h22,
  parameter bit          FAST_SIM  = 1'b1,
  parameter logic [23:0] WDOG_CYC  = 24'd1_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    INT,
  input  logic                    spi_done,
  input  logic [15:0]             spi_rd_data,
  output logic                    spi_wrt,
  output logic [15:0]             spi_cmd,
  output logic [16*NUM_AXES-1:0]  axis_data,
  output logic                    vld,
  output logic                    wdog_to
);

  localparam int         CW   = FAST_SIM ? 10 : 16;
  localparam logic [2:0] LAST = 3'(NUM_AXES - 1);

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [2:0]              idx_q;
  logic [16*NUM_AXES-1:0]  shadow_q;
  logic [16*NUM_AXES-1:0]  axis_q;
  logic                    vld_q;
  logic                    wrt_q;
  logic [15:0]             cmd_q;
  logic                    int_s;
  logic [6:0]              lo_addr;
  logic [6:0]              hi_addr;
  logic [6:0]              nx_addr;
  logic                    wd_hit;
  logic                    unused_rd_hi;

  inert_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (INT),
    .q_o (int_s)
  );

  // 7-bit wrapping register addresses for the current and next axis
  assign lo_addr = BASE_ADDR + {3'b000, idx_q, 1'b0};
  assign hi_addr = lo_addr + 7'd1;
  assign nx_addr = lo_addr + 7'd2;

  assign unused_rd_hi = ^spi_rd_data[15:8];

`ifdef INERT_WDOG_EN
  logic [23:0] wd_q;
  logic        wd_to_q;
  logic        wd_run;

  assign wd_run  = (state_q == IDLE) || (state_q == RD_L) ||
                   (state_q == RD_H);
  assign wd_hit  = wd_run && (wd_q == WDOG_CYC - 24'd1);
  assign wdog_to = wd_to_q;
`else
  assign wd_hit  = 1'b0;
  assign wdog_to = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT_WAIT;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      axis_q   <= '0;
      vld_q    <= 1'b0;
      wrt_q    <= 1'b0;
      cmd_q    <= '0;
`ifdef INERT_WDOG_EN
      wd_q     <= '0;
      wd_to_q  <= 1'b0;
`endif
    end else begin
      wrt_q <= 1'b0;
      vld_q <= 1'b0;
`ifdef INERT_WDOG_EN
      wd_to_q <= 1'b0;
      if (state_q == PUBLISH || wd_hit) begin
        wd_q <= '0;
      end else if (wd_run) begin
        wd_q <= wd_q + 24'd1;
      end
`endif
      if (wd_hit) begin
        // Abandon everything and reconfigure; published data stays.
`ifdef INERT_WDOG_EN
        wd_to_q <= 1'b1;
`endif
        state_q <= INIT_WAIT;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          INIT_WAIT: begin
            cnt_q <= cnt_q + 1'b1;
            if (&cnt_q) begin
              wrt_q   <= 1'b1;
              cmd_q   <= CMD_CFG0;
              state_q <= CFG0;
            end
          end
          CFG0: begin
            if (spi_done) begin
              wrt_q   <= 1'b1;
              cmd_q   <= CMD_CFG1;
              state_q <= CFG1;
            end
          end
          CFG1: begin
            if (spi_done) begin
              wrt_q   <= 1'b1;
              cmd_q   <= CMD_CFG2;
              state_q <= CFG2;
            end
          end
          CFG2: begin
            if (spi_done) begin
              state_q <= IDLE;
            end
          end
          IDLE: begin
            if (int_s) begin
              idx_q   <= '0;
              wrt_q   <= 1'b1;
              cmd_q   <= rd_cmd(BASE_ADDR);
              state_q <= RD_L;
            end
          end
          RD_L: begin
            if (spi_done) begin
              for (int a = 0; a < NUM_AXES; a++) begin
                if (idx_q == 3'(a)) begin
                  shadow_q[16*a +: 8] <= spi_rd_data[7:0];
                end
              end
              wrt_q   <= 1'b1;
              cmd_q   <= rd_cmd(hi_addr);
              state_q <= RD_H;
            end
          end
          RD_H: begin
            if (spi_done) begin
              for (int a = 0; a < NUM_AXES; a++) begin
                if (idx_q == 3'(a)) begin
                  shadow_q[16*a+8 +: 8] <= spi_rd_data[7:0];
                end
              end
              if (idx_q < LAST) begin
                idx_q   <= idx_q + 3'd1;
                wrt_q   <= 1'b1;
                cmd_q   <= rd_cmd(nx_addr);
                state_q <= RD_L;
              end else begin
                state_q <= PUBLISH;
              end
            end
          end
          PUBLISH: begin
            axis_q  <= shadow_q;
            vld_q   <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= INIT_WAIT;
        endcase
      end
    end
  end

  assign spi_wrt   = wrt_q;
  assign spi_cmd   = cmd_q;
  assign axis_data = axis_q;
  assign vld       = vld_q;

endmodule

// File: doc/inert_multi_intf.md
INERT_MULTI_INTF -- requirements
Module: inert_multi_intf

Interface
REQ-001 Parameter NUM_AXES, default 3: number of consecutive 16-bit sensor axes read per frame (1..6).
REQ-002 Parameter BASE_ADDR, default 7'h22: register address of axis 0 low byte.
REQ-003 Parameter FAST_SIM, default 1: startup wait counter is 10 bits when 1, 16 bits when 0.
REQ-004 Parameter WDOG_CYC, default 24'd1_000_000: watchdog limit in clk cycles.
REQ-005 clk  in  1  single system clock; all logic on posedge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 INT  in  1  asynchronous sensor data-ready.
REQ-008 spi_done  in  1  SPI transaction complete pulse.
REQ-009 spi_rd_data  in  16  SPI read data; low byte carries register contents.
REQ-010 spi_wrt  out  1  one-cycle SPI start strobe.
REQ-011 spi_cmd  out  16  SPI command word, held stable from spi_wrt until spi_done.
REQ-012 axis_data  out  16*NUM_AXES  axis i in bits [16i+15:16i], signed two's complement.
REQ-013 vld  out  1  one-cycle pulse when axis_data has updated.
REQ-014 wdog_to  out  1  one-cycle pulse on watchdog expiry (macro-dependent).

Function
REQ-015 INT is double-flopped before use; only the synchronized version is used.
REQ-016 States: INIT_WAIT, CFG0, CFG1, CFG2, IDLE, RD_L, RD_H, PUBLISH.
REQ-017 INIT_WAIT: counter increments each cycle; when all ones, issue spi_wrt with cmd 16'h0D02, go to CFG0.
REQ-018 CFG0 on spi_done: spi_wrt with 16'h1160, go to CFG1; CFG1 on spi_done: spi_wrt with 16'h1440, go to CFG2; CFG2 on spi_done: go to IDLE.
REQ-019 IDLE with synchronized INT high: axis index <= 0, spi_wrt with read cmd for low byte, go to RD_L.
REQ-020 Read cmd = {1'b1, addr[6:0], 8'h00}; axis i low addr = BASE_ADDR+2i, high addr = BASE_ADDR+2i+1.
REQ-021 RD_L on spi_done: capture spi_rd_data[7:0] into shadow low byte of axis i; spi_wrt high-byte read, go to RD_H.
REQ-022 RD_H on spi_done: capture high byte; if i < NUM_AXES-1 increment i, spi_wrt next low read, go to RD_L; else go to PUBLISH.
REQ-023 PUBLISH: copy all shadow registers to axis_data in one cycle, go to IDLE; vld asserts the following cycle, coincident with the new axis_data value already visible.
REQ-024 axis_data never shows a partially updated frame.
REQ-025 spi_done in IDLE or INIT_WAIT is ignored; spi_wrt is never issued while a transaction is outstanding.
REQ-026 INT still high on return to IDLE starts a new frame immediately (back-to-back frames allowed).
REQ-027 Address arithmetic is 7-bit modulo; BASE_ADDR+2*NUM_AXES overflow wraps and is a configuration error, not checked.

Reset
REQ-028 rst in any state, including mid-transaction: state <= INIT_WAIT, counter, index, shadow, axis_data <= 0, vld/spi_wrt/wdog_to <= 0, spi_cmd <= 0, synchronizer flops <= 0.
REQ-029 After rst deasserts, the full startup wait and three-command configuration repeat.

Configuration
REQ-030 Macro INERT_WDOG_EN defined: cycle counter runs in IDLE and during reads; cleared on vld; reaching WDOG_CYC pulses wdog_to, clears counter, returns to INIT_WAIT (full reconfigure, axis_data retained).
REQ-031 INERT_WDOG_EN undefined: no watchdog logic; wdog_to tied 0; IDLE waits indefinitely.

Structure
REQ-032 Package inert_pkg: state enum, config command constants (16'h0D02, 16'h1160, 16'h1440), read-bit constant.
REQ-033 One sub-module natural: inert_sync2, the two-flop INT synchronizer with synchronous active-high reset.
REQ-034 SPI master stays external; this block drives only its handshake ports.

Verification
REQ-035 Post-reset, FAST_SIM=1: first spi_wrt at cycle 1024 (+/-1) with spi_cmd 16'h0D02; then 16'h1160, 16'h1440 each one cycle after spi_done.
REQ-036 NUM_AXES=3, INT high, sensor model returns X=16'h1234, Y=16'hFF00, Z=16'h8001: commands A200,A300,A400,A500,A600,A700 in order; vld once; axis_data = 48'h8001_FF00_1234.
REQ-037 NUM_AXES=1, BASE_ADDR=7'h26: commands A600,A700 only; axis_data = read value; axis_data unchanged before vld.
REQ-038 rst asserted during RD_H of axis 1: next cycle all outputs 0, state INIT_WAIT; no vld; config sequence repeats.
REQ-039 INERT_WDOG_EN, WDOG_CYC=500, INT held low after config: wdog_to pulses at 500 cycles, spi_cmd 16'h0D02 follows after startup wait; without the macro, no spi_wrt ever occurs.
REQ-040 INT held high continuously: consecutive frames with vld spacing = 2*NUM_AXES transactions + 2 cycles; no spi_wrt overlaps an outstanding transaction.
